// File: rtl/half_duplex_spi_slave.sv
// ---------------------------------------------------------------------------
// half_duplex_spi_slave
//
// Responder end of the 3-wire half-duplex SPI link. The master sends, MSB
// first, an R/W bit (1 = read), ADDR_WIDTH address bits and DATA_WIDTH data
// bits on the shared SDIO line. A write frame becomes a single reg_wr_en
// strobe. A read frame becomes a single reg_rd_en strobe, and the returned
// word is shifted back out on SDIO. SCLK, CS_n and SDIO are oversampled by
// fabric_clk, which must run at least 8x the SCLK rate, so the whole block
// lives in one clock domain.
//
// Ports
//   fabric_clk, reset     block clock, asynchronous active-high reset
//   spi_cpol, spi_cpha    SPI mode, taken only while idle
//   spi_sclk, spi_cs_n    asynchronous SPI clock / chip select from master
//   spi_sdio              shared data line, driven only while sdio_oe is high
//   sdio_oe               drive-enable mirror
//   reg_addr, reg_wdata   register-bus address and write data
//   reg_wr_en, reg_rd_en  one-cycle write / read strobes
//   reg_rdata             read data, valid one cycle after reg_rd_en
//   frame_error           one-cycle pulse when a frame is aborted
// ---------------------------------------------------------------------------
module half_duplex_spi_slave #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  fabric_clk,
  input  logic                  reset,
  input  logic                  spi_cpol,
  input  logic                  spi_cpha,
  input  logic                  spi_sclk,
  input  logic                  spi_cs_n,
  inout  wire                   spi_sdio,
  output logic                  sdio_oe,
  output logic [ADDR_WIDTH-1:0] reg_addr,
  output logic [DATA_WIDTH-1:0] reg_wdata,
  output logic                  reg_wr_en,
  output logic                  reg_rd_en,
  input  logic [DATA_WIDTH-1:0] reg_rdata,
  output logic                  frame_error
);

  localparam int FRAME_BITS = 1 + ADDR_WIDTH + DATA_WIDTH;
  localparam int CNT_W      = $clog2(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_CMD = CNT_W'(ADDR_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(ADDR_WIDTH + DATA_WIDTH);

  typedef enum logic [2:0] {IDLE, CMD, WDATA, RD_FETCH, RDATA, DONE} state_t;

  logic sclk_meta_q, sclk_sync_q, sclk_dly_q;
  logic cs_meta_q, cs_sync_q, cs_dly_q;
  logic sdio_meta_q, sdio_sync_q;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] cmd_q, cmd_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  cpol_q, cpol_d, cpha_q, cpha_d;
  logic [ADDR_WIDTH-1:0] reg_addr_q, reg_addr_d;
  logic [DATA_WIDTH-1:0] reg_wdata_q, reg_wdata_d;
  logic                  sdio_oe_q, sdio_oe_d;
  logic                  sdio_out_q, sdio_out_d;
  logic                  reg_rd_en_q, reg_rd_en_d;
  logic                  wr_pend_q, wr_pend_d;
  logic                  reg_wr_en_q, reg_wr_en_d;
  logic                  frame_error_q, frame_error_d;

  logic                  sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic                  lead_edge, trail_edge, sample_edge, drive_edge;
  logic [ADDR_WIDTH:0]   cmd_next;
  logic [DATA_WIDTH-1:0] data_next;

  // Two-flop synchronisers. CS_n resets high so a frame can only begin on a
  // genuine fall seen after reset. SCLK keeps one extra delayed copy for
  // edge detection.
  always_ff @(posedge fabric_clk or posedge reset) begin
    if (reset) begin
      sclk_meta_q <= 1'b0;
      sclk_sync_q <= 1'b0;
      sclk_dly_q  <= 1'b0;
      cs_meta_q   <= 1'b1;
      cs_sync_q   <= 1'b1;
      cs_dly_q    <= 1'b1;
      sdio_meta_q <= 1'b0;
      sdio_sync_q <= 1'b0;
    end else begin
      sclk_meta_q <= spi_sclk;
      sclk_sync_q <= sclk_meta_q;
      sclk_dly_q  <= sclk_sync_q;
      cs_meta_q   <= spi_cs_n;
      cs_sync_q   <= cs_meta_q;
      cs_dly_q    <= cs_sync_q;
      sdio_meta_q <= spi_sdio;
      sdio_sync_q <= sdio_meta_q;
    end
  end

  assign sclk_rise = sclk_sync_q & ~sclk_dly_q;
  assign sclk_fall = ~sclk_sync_q & sclk_dly_q;
  assign cs_rise   = cs_sync_q & ~cs_dly_q;
  assign cs_fall   = ~cs_sync_q & cs_dly_q;

  // The leading edge is SCLK leaving its idle level; CPHA picks whether data
  // is sampled on the leading or the trailing edge.
  assign lead_edge   = cpol_q ? sclk_fall : sclk_rise;
  assign trail_edge  = cpol_q ? sclk_rise : sclk_fall;
  assign sample_edge = cpha_q ? trail_edge : lead_edge;
  assign drive_edge  = cpha_q ? lead_edge : trail_edge;

  // SDIO passes through the same synchroniser depth as SCLK, so the bit
  // seen alongside a detected edge is the one present at that pin edge.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    cmd_d         = cmd_q;
    data_d        = data_q;
    cpol_d        = cpol_q;
    cpha_d        = cpha_q;
    reg_addr_d    = reg_addr_q;
    reg_wdata_d   = reg_wdata_q;
    sdio_oe_d     = sdio_oe_q;
    sdio_out_d    = sdio_out_q;
    reg_rd_en_d   = 1'b0;
    wr_pend_d     = 1'b0;
    reg_wr_en_d   = wr_pend_q;
    frame_error_d = 1'b0;
    cmd_next      = {cmd_q, sdio_sync_q};
    data_next     = {data_q[DATA_WIDTH-2:0], sdio_sync_q};

    // An abort outranks any edge seen in the same cycle, including the
    // final write sample, so no write strobe is queued.
    if (cs_rise && (state_q inside {CMD, WDATA, RD_FETCH, RDATA})) begin
      state_d       = IDLE;
      sdio_oe_d     = 1'b0;
      frame_error_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          sdio_oe_d = 1'b0;
          cpol_d    = spi_cpol;
          cpha_d    = spi_cpha;
          cnt_d     = '0;
          cmd_d     = '0;
          if (cs_fall) state_d = CMD;
        end
        CMD: begin
          if (sample_edge) begin
            cmd_d = cmd_next[ADDR_WIDTH-1:0];
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_CMD) begin
              reg_addr_d = cmd_next[ADDR_WIDTH-1:0];
              if (cmd_next[ADDR_WIDTH]) begin
                state_d     = RD_FETCH;
                reg_rd_en_d = 1'b1;
              end else begin
                state_d = WDATA;
              end
            end
          end
        end
        WDATA: begin
          if (sample_edge) begin
            data_d = data_next;
            cnt_d  = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_BIT) begin
              reg_wdata_d = data_next;
              wr_pend_d   = 1'b1;
              state_d     = DONE;
            end
          end
        end
        // First cycle here is the strobe itself; reg_rdata is valid on the
        // cycle after, once the strobe has dropped.
        RD_FETCH: begin
          if (!reg_rd_en_q) begin
            data_d  = reg_rdata;
            state_d = RDATA;
          end
        end
        RDATA: begin
          if (drive_edge) begin
            sdio_oe_d  = 1'b1;
            sdio_out_d = data_q[DATA_WIDTH-1];
            data_d     = {data_q[DATA_WIDTH-2:0], 1'b0};
            cnt_d      = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_BIT) state_d = DONE;
          end
        end
        // The counter is simply held here, so extra SCLK periods are harmless.
        DONE: begin
          if (cs_rise) begin
            sdio_oe_d = 1'b0;
            state_d   = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge fabric_clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      cmd_q         <= '0;
      data_q        <= '0;
      cpol_q        <= 1'b0;
      cpha_q        <= 1'b0;
      reg_addr_q    <= '0;
      reg_wdata_q   <= '0;
      sdio_oe_q     <= 1'b0;
      sdio_out_q    <= 1'b0;
      reg_rd_en_q   <= 1'b0;
      wr_pend_q     <= 1'b0;
      reg_wr_en_q   <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cmd_q         <= cmd_d;
      data_q        <= data_d;
      cpol_q        <= cpol_d;
      cpha_q        <= cpha_d;
      reg_addr_q    <= reg_addr_d;
      reg_wdata_q   <= reg_wdata_d;
      sdio_oe_q     <= sdio_oe_d;
      sdio_out_q    <= sdio_out_d;
      reg_rd_en_q   <= reg_rd_en_d;
      wr_pend_q     <= wr_pend_d;
      reg_wr_en_q   <= reg_wr_en_d;
      frame_error_q <= frame_error_d;
    end
  end

  assign spi_sdio    = sdio_oe_q ? sdio_out_q : 1'bz;
  assign sdio_oe     = sdio_oe_q;
  assign reg_addr    = reg_addr_q;
  assign reg_wdata   = reg_wdata_q;
  assign reg_wr_en   = reg_wr_en_q;
  assign reg_rd_en   = reg_rd_en_q;
  assign frame_error = frame_error_q;

endmodule

// File: tb/tb_half_duplex_spi_slave.sv
// ---------------------------------------------------------------------------
// tb_half_duplex_spi_slave
//
// Directed bench for half_duplex_spi_slave. A behavioural SPI master drives
// frames in all four modes. A small register model answers read strobes, and
// a monitor counts strobes, error pulses and SDIO drive/contention cycles.
// Expected values are the hand-chosen frame contents.
// ---------------------------------------------------------------------------
module tb_half_duplex_spi_slave;

  logic        fabric_clk = 1'b0;
  logic        reset      = 1'b1;
  logic        spi_cpol   = 1'b0;
  logic        spi_cpha   = 1'b0;
  logic        spi_sclk   = 1'b0;
  logic        spi_cs_n   = 1'b1;
  logic        master_oe  = 1'b0;
  logic        master_drv = 1'b0;
  wire         spi_sdio;
  logic        sdio_oe;
  logic [6:0]  reg_addr;
  logic [15:0] reg_wdata;
  logic        reg_wr_en;
  logic        reg_rd_en;
  logic [15:0] reg_rdata  = 16'h0000;
  logic        frame_error;
  logic [15:0] rd_model   = 16'h0000;

  int          compCount     = 0;
  int          errCount      = 0;
  int          wrCount       = 0;
  int          rdCount       = 0;
  int          errPulseCount = 0;
  int          oeCycles      = 0;
  int          clashCycles   = 0;
  logic [6:0]  lastWrAddr    = 7'h00;
  logic [6:0]  lastRdAddr    = 7'h00;
  logic [15:0] lastWdata     = 16'h0000;
  logic [15:0] capData;

  assign spi_sdio = master_oe ? master_drv : 1'bz;

  half_duplex_spi_slave #(.ADDR_WIDTH(7), .DATA_WIDTH(16)) dut (
    .fabric_clk (fabric_clk),
    .reset      (reset),
    .spi_cpol   (spi_cpol),
    .spi_cpha   (spi_cpha),
    .spi_sclk   (spi_sclk),
    .spi_cs_n   (spi_cs_n),
    .spi_sdio   (spi_sdio),
    .sdio_oe    (sdio_oe),
    .reg_addr   (reg_addr),
    .reg_wdata  (reg_wdata),
    .reg_wr_en  (reg_wr_en),
    .reg_rd_en  (reg_rd_en),
    .reg_rdata  (reg_rdata),
    .frame_error(frame_error)
  );

  // 100 MHz fabric clock; SCLK half-periods are six fabric cycles.
  always #5 fabric_clk = ~fabric_clk;

  // Register model: data is valid only during the cycle right after the
  // read strobe, and a poison value otherwise, so a late or early capture
  // shows up as wrong data.
  always @(posedge fabric_clk) begin
    reg_rdata <= reg_rd_en ? rd_model : 16'hDEAD;
  end

  // Monitor on the falling edge so every one-cycle pulse is seen exactly once.
  always @(negedge fabric_clk) begin
    if (reg_wr_en) begin
      wrCount    <= wrCount + 1;
      lastWrAddr <= reg_addr;
      lastWdata  <= reg_wdata;
    end
    if (reg_rd_en) begin
      rdCount    <= rdCount + 1;
      lastRdAddr <= reg_addr;
    end
    if (frame_error) errPulseCount <= errPulseCount + 1;
    if (sdio_oe) oeCycles <= oeCycles + 1;
    if (sdio_oe && master_oe) clashCycles <= clashCycles + 1;
  end

  // Single comparison point: counts and reports every check.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic halfPeriod();
    repeat (6) @(negedge fabric_clk);
  endtask

  // Switch SPI mode while CS_n is high and park SCLK at its idle level.
  task automatic setMode(input logic pol, input logic pha);
    @(negedge fabric_clk);
    spi_cpol = pol;
    spi_cpha = pha;
    spi_sclk = pol;
    repeat (4) @(negedge fabric_clk);
  endtask

  // Behavioural master: runs 'periods' SCLK periods of one frame. It changes
  // its data on drive edges, samples on sample edges, and releases SDIO on the
  // first drive edge of a read's data phase. CS_n rises half a period after
  // the last edge unless endCs is 0.
  task automatic applyStimulus(input logic rw, input logic [6:0] addr,
                               input logic [15:0] wdata, input int periods,
                               input logic endCs, output logic [15:0] rdata);
    logic [23:0] frame;
    int          bi;
    frame = {rw, addr, wdata};
    rdata = 16'h0000;
    @(negedge fabric_clk);
    spi_cs_n   = 1'b0;
    master_oe  = 1'b1;
    master_drv = frame[23];
    halfPeriod();
    for (int p = 0; p < periods; p++) begin
      if (!spi_cpha && rw && p >= 8 && p < 24) begin
        bi = 23 - p;
        rdata[bi] = spi_sdio;
      end
      if (spi_cpha && p < 24) begin
        if (rw && p >= 8) master_oe = 1'b0;
        else master_drv = frame[23-p];
      end
      spi_sclk = ~spi_sclk;
      halfPeriod();
      if (spi_cpha && rw && p >= 8 && p < 24) begin
        bi = 23 - p;
        rdata[bi] = spi_sdio;
      end
      if (!spi_cpha && p + 1 < 24) begin
        if (rw && p + 1 >= 8) master_oe = 1'b0;
        else master_drv = frame[22-p];
      end
      spi_sclk = ~spi_sclk;
      halfPeriod();
    end
    if (endCs) begin
      spi_cs_n  = 1'b1;
      master_oe = 1'b0;
    end
  endtask

  // One write frame followed by checks of the strobe count and captured values.
  task automatic doWrite(input logic [6:0] a, input logic [15:0] d, input int periods);
    int          wr0, rd0, err0, oe0;
    logic [15:0] unused;
    wr0  = wrCount;
    rd0  = rdCount;
    err0 = errPulseCount;
    oe0  = oeCycles;
    applyStimulus(1'b0, a, d, periods, 1'b1, unused);
    repeat (10) @(negedge fabric_clk);
    checkOutput("wr_strobes", 32'(wrCount - wr0), 32'd1);
    checkOutput("wr_no_rd", 32'(rdCount - rd0), 32'd0);
    checkOutput("wr_no_error", 32'(errPulseCount - err0), 32'd0);
    checkOutput("wr_oe_never", 32'(oeCycles - oe0), 32'd0);
    checkOutput("wr_addr", 32'(lastWrAddr), 32'(a));
    checkOutput("wr_data", 32'(lastWdata), 32'(d));
  endtask

  // One read frame: checks the strobe, the word the master captured, and
  // that SDIO stays driven until CS_n rises and is released within 4 cycles.
  task automatic doRead(input logic [6:0] a, input logic [15:0] model);
    int wr0, rd0, err0;
    rd_model = model;
    wr0  = wrCount;
    rd0  = rdCount;
    err0 = errPulseCount;
    applyStimulus(1'b1, a, 16'h0000, 24, 1'b1, capData);
    @(posedge fabric_clk);
    #1;
    checkOutput("rd_oe_held", 32'(sdio_oe), 32'd1);
    repeat (3) @(posedge fabric_clk);
    #1;
    checkOutput("rd_oe_released", 32'(sdio_oe), 32'd0);
    repeat (8) @(negedge fabric_clk);
    checkOutput("rd_strobes", 32'(rdCount - rd0), 32'd1);
    checkOutput("rd_no_wr", 32'(wrCount - wr0), 32'd0);
    checkOutput("rd_no_error", 32'(errPulseCount - err0), 32'd0);
    checkOutput("rd_addr", 32'(lastRdAddr), 32'(a));
    checkOutput("rd_master_data", 32'(capData), 32'(model));
  endtask

  // Directed sequence: reset, all four modes, abort, extra clocks, then a
  // reset in the middle of a read followed by a clean read.
  initial begin
    int          wr0, rd0, err0;
    logic [15:0] unused;

    repeat (3) @(negedge fabric_clk);
    checkOutput("rst_oe", 32'(sdio_oe), 32'd0);
    checkOutput("rst_addr", 32'(reg_addr), 32'd0);
    checkOutput("rst_wdata", 32'(reg_wdata), 32'd0);
    checkOutput("rst_wr_en", 32'(reg_wr_en), 32'd0);
    checkOutput("rst_rd_en", 32'(reg_rd_en), 32'd0);
    checkOutput("rst_error", 32'(frame_error), 32'd0);
    reset = 1'b0;
    repeat (5) @(negedge fabric_clk);

    $display("[TB] mode 0 write / mode 3 read");
    setMode(1'b0, 1'b0);
    doWrite(7'h15, 16'hA5C3, 24);
    setMode(1'b1, 1'b1);
    doRead(7'h2A, 16'h1234);

    $display("[TB] mode 1 and mode 2");
    setMode(1'b0, 1'b1);
    doWrite(7'h15, 16'hFFFF, 24);
    doRead(7'h2A, 16'h0001);
    setMode(1'b1, 1'b0);
    doWrite(7'h15, 16'h0001, 24);
    doRead(7'h2A, 16'hFFFF);

    $display("[TB] abort after 10 data bits");
    setMode(1'b0, 1'b0);
    wr0  = wrCount;
    err0 = errPulseCount;
    applyStimulus(1'b0, 7'h15, 16'h5A5A, 18, 1'b1, unused);
    repeat (10) @(negedge fabric_clk);
    checkOutput("abort_no_wr", 32'(wrCount - wr0), 32'd0);
    checkOutput("abort_error", 32'(errPulseCount - err0), 32'd1);
    doWrite(7'h01, 16'h00FF, 24);

    $display("[TB] extra SCLK periods");
    doWrite(7'h7F, 16'h8001, 30);

    $display("[TB] reset in the middle of a read");
    rd_model = 16'h5555;
    rd0 = rdCount;
    applyStimulus(1'b1, 7'h33, 16'h0000, 12, 1'b0, unused);
    checkOutput("midrd_strobe", 32'(rdCount - rd0), 32'd1);
    checkOutput("midrd_oe_on", 32'(sdio_oe), 32'd1);
    @(negedge fabric_clk);
    reset = 1'b1;
    #1;
    checkOutput("midrd_rst_oe", 32'(sdio_oe), 32'd0);
    checkOutput("midrd_rst_addr", 32'(reg_addr), 32'd0);
    checkOutput("midrd_rst_wdata", 32'(reg_wdata), 32'd0);
    checkOutput("midrd_rst_wr_en", 32'(reg_wr_en), 32'd0);
    checkOutput("midrd_rst_rd_en", 32'(reg_rd_en), 32'd0);
    checkOutput("midrd_rst_error", 32'(frame_error), 32'd0);
    @(negedge fabric_clk);
    spi_cs_n = 1'b1;
    spi_sclk = spi_cpol;
    repeat (3) @(negedge fabric_clk);
    reset = 1'b0;
    repeat (6) @(negedge fabric_clk);
    doRead(7'h10, 16'hBEEF);

    checkOutput("no_contention", 32'(clashCycles), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, errCount);
    $finish;
  end

endmodule
